gemv_stream_ctrl: RTL and testbench

- Streaming front/back end for the GEMV systolic array (array_top).
- Accepts a DW-bit valid/ready word stream and assembles the SZ*SZ matrix A and SZ-element vector W into the registers that drive array_top.
- Pulses the array enable, waits with a timeout for the array's valid, captures O, and drains it as a valid/ready output stream.
- Sits directly between the host/DMA stream and array_top.

---
 rtl/gemv_pkg.sv | 35 +++
 rtl/gemv_out_drain.sv | 54 +++++
 rtl/gemv_stream_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gemv_stream_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemv_pkg.sv
// Shared types and constants for the GEMV stream controller.
// Build option: GEMV_CYCLE_CNT_EN (see gemv_stream_ctrl.sv) adds a launch-to-capture cycle counter.
package gemv_pkg;

  localparam int GEMV_DW      = 16;
  localparam int GEMV_SZ      = 3;
  localparam int GEMV_TIMEOUT = 16;

  typedef logic [GEMV_DW-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_W = 3'd2,
    LAUNCH = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the word index while streaming A (covers SZ*SZ words).
  function automatic int a_idx_width(input int sz);
    return idx_width(sz * sz);
  endfunction

  // Width of the WAIT timer (counts 0 .. TIMEOUT-1).
  function automatic int tmr_width(input int timeout);
    return idx_width(timeout);
  endfunction

endpackage

// File: rtl/gemv_out_drain.sv
// Result holding registers plus valid/ready serializer for the array output O.
// A capture strobe loads all SZ words at once; done_o pulses with the last handshake.
module gemv_out_drain
  import gemv_pkg::*;
#(
  parameter int DW = GEMV_DW,
  parameter int SZ = GEMV_SZ
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          cap_i,
  input  logic [DW-1:0] cap_data_i [SZ],
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          done_o
);

  localparam int OIDX_W = idx_width(SZ);
  localparam logic [OIDX_W-1:0] O_LAST = OIDX_W'(SZ - 1);

  logic [DW-1:0]     res [SZ];
  logic [OIDX_W-1:0] idx;
  logic              busy;
  logic              hs;

  assign hs          = busy & out_ready_i;
  assign out_valid_o = busy;
  assign out_data_o  = busy ? res[idx] : '0;
  assign out_last_o  = busy && (idx == O_LAST);
  assign done_o      = hs && (idx == O_LAST);

  // Load results on capture, then step through them one handshake at a time.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      busy <= 1'b0;
      idx  <= '0;
      for (int i = 0; i < SZ; i++) res[i] <= '0;
    end else if (cap_i) begin
      res  <= cap_data_i;
      idx  <= '0;
      busy <= 1'b1;
    end else if (hs) begin
      if (idx == O_LAST) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemv_stream_ctrl.sv
// Streaming front/back end for the GEMV systolic array: assembles A and W from a
// word stream, launches the array, waits (with timeout) for its result and drains O.
// Build option: define GEMV_CYCLE_CNT_EN to add cyc_cnt_o, the number of cycles from
// LAUNCH (counted as 1) through the WAIT cycle that captured the result.
module gemv_stream_ctrl
  import gemv_pkg::*;
#(
  parameter int DW      = GEMV_DW,
  parameter int SZ      = GEMV_SZ,
  parameter int TIMEOUT = GEMV_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          keep_a_i,
  output logic [DW-1:0] arr_a_o [SZ*SZ],
  output logic [DW-1:0] arr_w_o [SZ],
  output logic          arr_en_o,
  input  logic          arr_valid_i,
  input  logic [DW-1:0] arr_o_i [SZ],
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          err_o
`ifdef GEMV_CYCLE_CNT_EN
  ,
  output logic [31:0]   cyc_cnt_o
`endif
);

  localparam int IDX_W  = a_idx_width(SZ);
  localparam int WIDX_W = idx_width(SZ);
  localparam int TMR_W  = tmr_width(TIMEOUT);

  localparam logic [IDX_W-1:0] A_LAST   = IDX_W'(SZ * SZ - 1);
  localparam logic [IDX_W-1:0] W_LAST   = IDX_W'(SZ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] tmr;
  logic             a_loaded;
  logic             cap;
  logic             drain_done;

  // Input is only accepted while a matrix or vector is being assembled.
  assign in_ready_o = (state == IDLE) || (state == LOAD_A) || (state == LOAD_W);
  assign cap        = (state == WAIT) && arr_valid_i;

  // Transaction sequencer: stream assembly, launch, timed wait, drain hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      idx      <= '0;
      tmr      <= '0;
      a_loaded <= 1'b0;
      arr_en_o <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 0; i < SZ * SZ; i++) arr_a_o[i] <= '0;
      for (int i = 0; i < SZ; i++)      arr_w_o[i] <= '0;
    end else begin
      arr_en_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (keep_a_i && a_loaded) begin
              // Stored A is reused: this first word is already W[0].
              arr_w_o[0] <= in_data_i;
              if (SZ == 1) begin
                state    <= LAUNCH;
                arr_en_o <= 1'b1;
                idx      <= '0;
              end else begin
                state <= LOAD_W;
                idx   <= IDX_W'(1);
              end
            end else begin
              arr_a_o[0] <= in_data_i;
              if (SZ == 1) begin
                a_loaded <= 1'b1;
                state    <= LOAD_W;
                idx      <= '0;
              end else begin
                a_loaded <= 1'b0;
                state    <= LOAD_A;
                idx      <= IDX_W'(1);
              end
            end
          end
        end
        LOAD_A: begin
          if (in_valid_i) begin
            arr_a_o[idx] <= in_data_i;
            if (idx == A_LAST) begin
              a_loaded <= 1'b1;
              state    <= LOAD_W;
              idx      <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (in_valid_i) begin
            arr_w_o[idx[WIDX_W-1:0]] <= in_data_i;
            if (idx == W_LAST) begin
              // Enable is registered so it is high for exactly the LAUNCH cycle.
              state    <= LAUNCH;
              arr_en_o <= 1'b1;
              idx      <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LAUNCH: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (arr_valid_i) begin
            state <= DRAIN;
            idx   <= '0;
          end else if (tmr == TMR_LAST) begin
            // Give up; A/W and a_loaded survive so the host can retry with keep_a_i.
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gemv_out_drain #(
    .DW (DW),
    .SZ (SZ)
  ) u_drain (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .cap_i       (cap),
    .cap_data_i  (arr_o_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .done_o      (drain_done)
  );

`ifdef GEMV_CYCLE_CNT_EN
  logic [31:0] run_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Running launch-to-capture count; published only when the result is captured.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      run_cnt   <= '0;
      cyc_cnt_o <= '0;
    end else if (state == LAUNCH) begin
      run_cnt <= 32'd1;
    end else if (state == WAIT) begin
      if (arr_valid_i) cyc_cnt_o <= sat_inc(run_cnt);
      else             run_cnt   <= sat_inc(run_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_gemv_stream_ctrl.sv
// Directed bench for gemv_stream_ctrl with a stub array that answers 2 cycles after enable.
module tb_gemv_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        keep_a_i;
  logic [15:0] arr_a_o [9];
  logic [15:0] arr_w_o [3];
  logic        arr_en_o;
  logic        arr_valid_i;
  logic [15:0] arr_o [3];
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_last_o;
  logic        err_o;
`ifdef GEMV_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_o;
`endif

  int nvec = 0;
  int nmis = 0;
  int acc_total = 0;
  int en_total = 0;
  int err_total = 0;

  logic       stub_on;
  logic [1:0] en_dly;

  always #5 clk = ~clk;

  gemv_stream_ctrl dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .keep_a_i    (keep_a_i),
    .arr_a_o     (arr_a_o),
    .arr_w_o     (arr_w_o),
    .arr_en_o    (arr_en_o),
    .arr_valid_i (arr_valid_i),
    .arr_o_i     (arr_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
`ifdef GEMV_CYCLE_CNT_EN
    .cyc_cnt_o   (cyc_cnt_o),
`endif
    .err_o       (err_o)
  );

  // Stub array: valid two cycles after the enable pulse.
  always @(posedge clk) begin
    if (!rst_n_i) en_dly <= 2'b00;
    else          en_dly <= {en_dly[0], arr_en_o & stub_on};
  end
  assign arr_valid_i = en_dly[1];

  // Event counters sampled at the active edge.
  always @(posedge clk) begin
    if (rst_n_i) begin
      if (in_valid_i && in_ready_o) acc_total++;
      if (arr_en_o) en_total++;
      if (err_o) err_total++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic k, input int gap);
    int n;
    in_valid_i = 1'b0;
    repeat (gap) step();
    in_valid_i = 1'b1;
    in_data_i  = d;
    keep_a_i   = k;
    n = 0;
    while (!in_ready_o && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    keep_a_i   = 1'b0;
  endtask

  task automatic recv(input int e0, input int e1, input int e2, input bit bp);
    int          exp_w [3];
    int          got;
    bit          prev_stall;
    logic [15:0] prev_data;
    exp_w[0] = e0;
    exp_w[1] = e1;
    exp_w[2] = e2;
    got = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 200 && got < 3; c++) begin
      out_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_data", 32'(out_data_o), 32'(prev_data));
      end
      if (out_valid_o && out_ready_i) begin
        chk("out_data", 32'(out_data_o), 32'(exp_w[got]));
        chk("out_last", 32'(out_last_o), (got == 2) ? 32'd1 : 32'd0);
        got++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      step();
    end
    chk("recv_count", 32'(got), 32'd3);
    chk("post_drain_valid", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!arr_en_o && n < 60) begin
      step();
      n++;
    end
    chk("en_seen", 32'(arr_en_o), 32'd1);
  endtask

  initial begin
    int base;
    int base_en;
    int n;

    rst_n_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    keep_a_i    = 1'b0;
    out_ready_i = 1'b0;
    stub_on     = 1'b1;
    arr_o       = '{16'd14, 16'd32, 16'd50};
    repeat (3) step();

    // Reset state
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_arr_en", 32'(arr_en_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_out_data", 32'(out_data_o), 32'd0);
    chk("rst_out_last", 32'(out_last_o), 32'd0);
    chk("rst_a4", 32'(arr_a_o[4]), 32'd0);
    chk("rst_w2", 32'(arr_w_o[2]), 32'd0);
    rst_n_i = 1'b1;
    step();

    // keep_a_i=1 right after reset: A must still be loaded (12 words)
    base = acc_total;
    base_en = en_total;
    for (int k = 0; k < 9; k++) send(16'(k + 1), 1'b1, 0);
    for (int k = 0; k < 3; k++) send(16'(k + 1), 1'b1, 0);
    chk("txA_en_now", 32'(arr_en_o), 32'd1);
    chk("txA_words", 32'(acc_total - base), 32'd12);
    for (int k = 0; k < 9; k++) chk("txA_a", 32'(arr_a_o[k]), 32'(k + 1));
    for (int k = 0; k < 3; k++) chk("txA_w", 32'(arr_w_o[k]), 32'(k + 1));
    n = 0;
    while (!out_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("txA_latency", 32'(n), 32'd3);
    chk("txA_en_pulses", 32'(en_total - base_en), 32'd1);
    chk("txA_en_low", 32'(arr_en_o), 32'd0);
    recv(14, 32, 50, 1'b0);
`ifdef GEMV_CYCLE_CNT_EN
    chk("txA_cyc_cnt", cyc_cnt_o, 32'd3);
`endif

    // keep_a_i=1 with A loaded: only W is consumed, with input gaps and backpressure
    arr_o = '{16'd28, 16'd64, 16'd100};
    base = acc_total;
    base_en = en_total;
    send(16'd2, 1'b1, 1);
    send(16'd4, 1'b1, 0);
    send(16'd6, 1'b1, 2);
    wait_en();
    chk("txB_words", 32'(acc_total - base), 32'd3);
    for (int k = 0; k < 9; k++) chk("txB_a_kept", 32'(arr_a_o[k]), 32'(k + 1));
    chk("txB_w0", 32'(arr_w_o[0]), 32'd2);
    chk("txB_w1", 32'(arr_w_o[1]), 32'd4);
    chk("txB_w2", 32'(arr_w_o[2]), 32'd6);
    recv(28, 64, 100, 1'b1);
    chk("txB_en_pulses", 32'(en_total - base_en), 32'd1);

    // keep_a_i=0 reloads A
    arr_o = '{16'd7, 16'd8, 16'd9};
    base = acc_total;
    for (int k = 0; k < 9; k++) send(16'(9 - k), 1'b0, k % 2);
    for (int k = 0; k < 3; k++) send(16'd1, 1'b0, 1);
    wait_en();
    chk("txC_words", 32'(acc_total - base), 32'd12);
    for (int k = 0; k < 9; k++) chk("txC_a", 32'(arr_a_o[k]), 32'(9 - k));
    recv(7, 8, 9, 1'b1);

    // Timeout: stub silent
    stub_on = 1'b0;
    base = acc_total;
    send(16'd5, 1'b1, 0);
    send(16'd6, 1'b1, 0);
    send(16'd7, 1'b1, 0);
    chk("txT_words", 32'(acc_total - base), 32'd3);
    chk("txT_en_now", 32'(arr_en_o), 32'd1);
    n = 0;
    while (!err_o && n < 40) begin
      step();
      n++;
    end
    chk("txT_err_delay", 32'(n), 32'd17);
    chk("txT_idle_ready", 32'(in_ready_o), 32'd1);
    chk("txT_no_out", 32'(out_valid_o), 32'd0);
    step();
    chk("txT_err_one_cycle", 32'(err_o), 32'd0);
    chk("txT_err_count", 32'(err_total), 32'd1);

    // Retry after timeout reuses A
    stub_on = 1'b1;
    arr_o = '{16'd1, 16'd2, 16'd3};
    base = acc_total;
    send(16'd1, 1'b1, 0);
    send(16'd0, 1'b1, 0);
    send(16'd0, 1'b1, 0);
    wait_en();
    chk("txR_words", 32'(acc_total - base), 32'd3);
    chk("txR_a0", 32'(arr_a_o[0]), 32'd9);
    chk("txR_a8", 32'(arr_a_o[8]), 32'd1);
    chk("txR_w0", 32'(arr_w_o[0]), 32'd1);
    recv(1, 2, 3, 1'b0);

    // Reset in LOAD_A after 5 words
    for (int k = 0; k < 5; k++) send(16'(10 + k), 1'b0, 0);
    rst_n_i = 1'b0;
    step();
    chk("rstA_in_ready", 32'(in_ready_o), 32'd1);
    chk("rstA_out_valid", 32'(out_valid_o), 32'd0);
    chk("rstA_arr_en", 32'(arr_en_o), 32'd0);
    chk("rstA_err", 32'(err_o), 32'd0);
    chk("rstA_a0", 32'(arr_a_o[0]), 32'd0);
    chk("rstA_a4", 32'(arr_a_o[4]), 32'd0);
    rst_n_i = 1'b1;
    step();

    // a_loaded cleared by reset: keep_a_i=1 still loads A
    arr_o = '{16'd4, 16'd5, 16'd6};
    base = acc_total;
    for (int k = 0; k < 9; k++) send(16'(20 + k), 1'b1, 0);
    for (int k = 0; k < 3; k++) send(16'(k + 1), 1'b1, 0);
    wait_en();
    chk("txD_words", 32'(acc_total - base), 32'd12);
    chk("txD_a8", 32'(arr_a_o[8]), 32'd28);

    // Reset during DRAIN while stalled
    out_ready_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("txD_out_valid", 32'(out_valid_o), 32'd1);
    chk("txD_out_data", 32'(out_data_o), 32'd4);
    step();
    step();
    chk("txD_held_data", 32'(out_data_o), 32'd4);
    chk("txD_held_last", 32'(out_last_o), 32'd0);
    rst_n_i = 1'b0;
    step();
    chk("rstD_out_valid", 32'(out_valid_o), 32'd0);
    chk("rstD_out_data", 32'(out_data_o), 32'd0);
    chk("rstD_out_last", 32'(out_last_o), 32'd0);
    chk("rstD_in_ready", 32'(in_ready_o), 32'd1);
    chk("rstD_err", 32'(err_o), 32'd0);
    chk("rstD_w0", 32'(arr_w_o[0]), 32'd0);
    rst_n_i = 1'b1;
    step();
    chk("rstD_err_count", 32'(err_total), 32'd1);

    // After reset in DRAIN, A must be reloaded again
    arr_o = '{16'd14, 16'd32, 16'd50};
    base = acc_total;
    for (int k = 0; k < 9; k++) send(16'(k + 1), 1'b1, 0);
    for (int k = 0; k < 3; k++) send(16'(k + 1), 1'b1, 0);
    wait_en();
    chk("txE_words", 32'(acc_total - base), 32'd12);
    recv(14, 32, 50, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
